// File: rtl/msg_scheduler.sv
// msg_scheduler: SHA-256 message schedule generator with a 16-word sliding window.
// Optional feature macro MSG_SCHED_ERR_EN adds a sticky err output flagging starts seen while busy.
module msg_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block,
  output logic         ready,
  output logic [31:0]  msg,
  output logic [6:0]   iteration,
  output logic         msg_valid,
  input  logic         msg_ack,
`ifdef MSG_SCHED_ERR_EN
  output logic         err,
`endif
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [31:0] w_q [16];
  logic [6:0]  iter_q;
  logic        ready_q, valid_q, done_q;
  logic [31:0] w_new_d;
  logic        last_d;
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  // next schedule word from the current window, and whether the word on display is the final round
  always_comb begin
    w_new_d = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
    last_d  = iter_q == 7'(ROUNDS - 1);
  end
  // control FSM with registered handshake outputs; the window shifts only on an advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          for (int i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
          iter_q  <= '0;
          state_q <= RUN;
          ready_q <= 1'b0;
          valid_q <= 1'b1;
        end
        RUN: if (msg_ack) begin
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new_d;
          iter_q  <= last_d ? 7'd0 : iter_q + 7'd1;
          state_q <= last_d ? DONE : RUN;
          valid_q <= !last_d;
          done_q  <= last_d;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
`ifdef MSG_SCHED_ERR_EN
  // sticky flag: any start while busy sets it, the next accepted start clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (start) err <= !ready_q;
  end
`endif
  assign ready     = ready_q;
  assign msg_valid = valid_q;
  assign done      = done_q;
  assign msg       = w_q[0];
  assign iteration = iter_q;
endmodule

// File: tb/tb_msg_scheduler.sv
// tb_msg_scheduler: self-checking bench for msg_scheduler (ROUNDS=64 and ROUNDS=16 instances).
module tb_msg_scheduler;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, msg_ack = 1'b0, start16 = 1'b0, ack16 = 1'b0;
  logic [511:0] block = '0;
  logic ready, msg_valid, done, ready16, valid16, done16;
  logic [31:0] msg, msg16;
  logic [6:0] iteration, iter16;
`ifdef MSG_SCHED_ERR_EN
  logic err, err16;
`endif
  int checks = 0, failures = 0;
  logic [31:0] ref_w [64];
  logic [31:0] cap [64];
  typedef struct { int t; logic [31:0] w; } vec_t;
  vec_t kat [5];
  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

  msg_scheduler #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block(block), .ready(ready),
    .msg(msg), .iteration(iteration), .msg_valid(msg_valid), .msg_ack(msg_ack),
`ifdef MSG_SCHED_ERR_EN
    .err(err),
`endif
    .done(done));

  msg_scheduler #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .block(block), .ready(ready16),
    .msg(msg16), .iteration(iter16), .msg_valid(valid16), .msg_ack(ack16),
`ifdef MSG_SCHED_ERR_EN
    .err(err16),
`endif
    .done(done16));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build_ref(input logic [511:0] b);
    for (int t = 0; t < 16; t++) ref_w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
  endtask

  // mode 0: ack always high, 1: one on / two off, 2: random ack; poke_at >= 0 pulses start at that round
  task automatic run64(input logic [511:0] b, input int mode, input int poke_at);
    int t, dones, dcyc;
    logic a;
    build_ref(b);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    block = b;
    start = 1'b1;
    msg_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", {msg_valid, iteration, msg}, {1'b1, 7'd0, ref_w[0]});
`ifdef MSG_SCHED_ERR_EN
    chk("err_clear", err, 0);
`endif
    t = 0; dones = 0; dcyc = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done) begin
        dones++;
        dcyc = cyc;
        chk("done_flags", {msg_valid, ready}, 2'b00);
      end
      if (msg_valid) begin
        if (t < 64) begin
          chk("word", {iteration, msg}, {7'(t), ref_w[t]});
          cap[t] = msg;
        end else chk("overrun", msg_valid, 0);
      end
      if (ready && dones > 0) break;
      a = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      msg_ack = a;
      start = poke_at >= 0 && t == poke_at && msg_valid;
      if (msg_valid && a) t++;
      @(negedge clk);
    end
    start = 1'b0;
    msg_ack = 1'b0;
    chk("done_once", 64'(dones), 1);
    chk("rounds", 64'(t), 64);
    chk("iter_after", iteration, 0);
    if (mode == 0) chk("done_latency", 64'(dcyc), 64);
`ifdef MSG_SCHED_ERR_EN
    chk("err_state", err, poke_at >= 0);
`endif
  endtask

  initial begin
    logic [511:0] rb;
    int t;
    kat[0] = '{0,  32'h61626380};
    kat[1] = '{1,  32'h00000000};
    kat[2] = '{15, 32'h00000018};
    kat[3] = '{16, 32'h61626380};
    kat[4] = '{17, 32'h000F0000};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_state", {ready, msg_valid, done, iteration, msg}, {1'b1, 1'b0, 1'b0, 7'd0, 32'd0});
    chk("rst_state16", {ready16, valid16, done16, iter16, msg16}, {1'b1, 1'b0, 1'b0, 7'd0, 32'd0});
`ifdef MSG_SCHED_ERR_EN
    chk("rst_err", {err, err16}, 2'b00);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // known-answer vectors for the "abc" block
    run64(ABC, 0, -1);
    for (int i = 0; i < 5; i++) chk($sformatf("kat_w%0d", kat[i].t), cap[kat[i].t], kat[i].w);
    run64(ABC, 1, -1);
    run64(ABC, 0, 10);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
      run64(rb, 2, r == 1 ? 5 : -1);
    end
    // reset mid-run abandons the block
    build_ref(ABC);
    block = ABC;
    start = 1'b1;
    msg_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (iteration != 7'd30 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_30", iteration, 30);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {ready, msg_valid, done, iteration, msg}, {1'b1, 1'b0, 1'b0, 7'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_ignored", {ready, msg_valid, done}, 3'b100);
    end
    for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
    build_ref(rb);
    block = rb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_w0", {msg_valid, iteration, msg}, {1'b1, 7'd0, ref_w[0]});
    msg_ack = 1'b0;
    @(negedge clk);
    chk("hold_w0", {msg_valid, iteration, msg}, {1'b1, 7'd0, ref_w[0]});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // ROUNDS=16: words equal the block, then back-to-back start across DONE
    build_ref(rb);
    ack16 = 1'b1;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    t = 0;
    for (int cyc = 0; cyc < 40 && !done16; cyc++) begin
      if (valid16) begin
        if (t < 16) chk("w16", {iter16, msg16}, {7'(t), ref_w[t]});
        else chk("overrun16", valid16, 0);
        t++;
      end
      @(negedge clk);
    end
    chk("done16", {done16, ready16, valid16}, 3'b100);
    chk("count16", 64'(t), 16);
    start16 = 1'b1;
    @(negedge clk);
    chk("b2b_ignored", {ready16, valid16, done16}, 3'b100);
`ifdef MSG_SCHED_ERR_EN
    chk("err16_set", err16, 1);
`endif
    @(negedge clk);
    start16 = 1'b0;
    chk("b2b_accept", {valid16, iter16, msg16}, {1'b1, 7'd0, ref_w[0]});
`ifdef MSG_SCHED_ERR_EN
    chk("err16_clear", err16, 0);
`endif
    t = 0;
    while (!done16 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done16_again", done16, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
